// File: rtl/instruction_fetch_tag_pkg.sv
// Shared core package for the fetch/tag stage.
// Holds the I-cache geometry and the two interface structs between
// instruction fetch (ift) and instruction decode (ifd).
package instruction_fetch_tag_pkg;

    localparam int ICACHE_CL_SIZE  = 64;
    localparam int ICACHE_NUM_WAYS = 4;
    localparam int ICACHE_NUM_SETS = 64;

    // Address split: offset [5:0], set [11:6], tag [31:12]
    localparam int ICACHE_OFFSET_W = 6;
    localparam int ICACHE_SET_W    = 6;
    localparam int ICACHE_TAG_W    = 20;

    typedef logic [ICACHE_SET_W-1:0] icache_set_t;
    typedef logic [ICACHE_TAG_W-1:0] icache_tag_t;

    // Feedback from decode: miss indication for the instruction on the
    // output register, plus refill tag updates.
    typedef struct packed {
        logic                       cache_miss;
        logic [ICACHE_NUM_WAYS-1:0] update_tag_en;
        icache_set_t                update_tag_set;
        icache_tag_t                update_tag;
    } ifd_ift_inf_t;

    // Fetched PC plus the raw tag/valid of every way for that set; the
    // hit compare happens downstream.
    typedef struct packed {
        logic                                         valid;
        logic [31:0]                                  pc;
        logic [ICACHE_NUM_WAYS-1:0][ICACHE_TAG_W-1:0] tag_rd;
        logic [ICACHE_NUM_WAYS-1:0]                   tag_valid;
    } ift_ifd_inf_t;

endpackage

// File: rtl/instruction_fetch_tag_tag_array.sv
// icache_tag_array: 4-way x 64-set tag/valid store with one combinational
// read port, per-way write enables, resettable valid bits and a
// write-to-read bypass so a same-cycle refill is visible immediately.
module icache_tag_array
    import instruction_fetch_tag_pkg::*;
(
    input  logic                                         clk,
    input  logic                                         rst,
    input  icache_set_t                                  rd_set_i,
    input  logic [ICACHE_NUM_WAYS-1:0]                   wr_en_i,
    input  icache_set_t                                  wr_set_i,
    input  icache_tag_t                                  wr_tag_i,
    output logic [ICACHE_NUM_WAYS-1:0][ICACHE_TAG_W-1:0] rd_tag_o,
    output logic [ICACHE_NUM_WAYS-1:0]                   rd_valid_o
);

    icache_tag_t                tag_q   [ICACHE_NUM_WAYS][ICACHE_NUM_SETS];
    logic [ICACHE_NUM_SETS-1:0] valid_q [ICACHE_NUM_WAYS];

    // Tag storage is not reset; the valid bits alone gate its meaning.
    always_ff @(posedge clk) begin
        for (int w = 0; w < ICACHE_NUM_WAYS; w++) begin
            if (wr_en_i[w] && !rst) begin
                tag_q[w][wr_set_i] <= wr_tag_i;
            end
        end
    end

    // Valid bits: cleared by reset (which wins over writes), set on write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < ICACHE_NUM_WAYS; w++) begin
                valid_q[w] <= '0;
            end
        end else begin
            for (int w = 0; w < ICACHE_NUM_WAYS; w++) begin
                if (wr_en_i[w]) begin
                    valid_q[w][wr_set_i] <= 1'b1;
                end
            end
        end
    end

    // Read port with bypass of a same-cycle write to the looked-up set.
    always_comb begin
        rd_tag_o   = '0;
        rd_valid_o = '0;
        for (int w = 0; w < ICACHE_NUM_WAYS; w++) begin
            if (wr_en_i[w] && (wr_set_i == rd_set_i)) begin
                rd_tag_o[w]   = wr_tag_i;
                rd_valid_o[w] = 1'b1;
            end else begin
                rd_tag_o[w]   = tag_q[w][rd_set_i];
                rd_valid_o[w] = valid_q[w][rd_set_i];
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_tag.sv
// instruction_fetch_tag: owns the fetch PC and the fetch->decode output
// register. Each normal cycle it looks up all ways of the current PC's
// set and registers PC plus tags for downstream hit detection.
module instruction_fetch_tag
    import instruction_fetch_tag_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic         pc_src,
    input  logic [31:0]  branch_target,
    input  ifd_ift_inf_t ifd_ift_inf,
    output ift_ifd_inf_t ift_ifd_inf
);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    ift_ifd_inf_t out_q, out_d;

    logic [ICACHE_NUM_WAYS-1:0][ICACHE_TAG_W-1:0] lk_tag;
    logic [ICACHE_NUM_WAYS-1:0]                   lk_valid;

    icache_tag_array u_tag_array (
        .clk        (clk),
        .rst        (rst),
        .rd_set_i   (fetch_pc_q[ICACHE_OFFSET_W +: ICACHE_SET_W]),
        .wr_en_i    (ifd_ift_inf.update_tag_en),
        .wr_set_i   (ifd_ift_inf.update_tag_set),
        .wr_tag_i   (ifd_ift_inf.update_tag),
        .rd_tag_o   (lk_tag),
        .rd_valid_o (lk_valid)
    );

    // Next PC / output priority: redirect > miss replay > stall > advance.
    // Redirect and replay hold the output fields but drop valid so the
    // replayed PC stays available on the output for the next replay.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_d      = out_q;
        if (pc_src) begin
            fetch_pc_d  = branch_target;
            out_d.valid = 1'b0;
        end else if (ifd_ift_inf.cache_miss) begin
            fetch_pc_d  = out_q.pc;
            out_d.valid = 1'b0;
        end else if (!stall) begin
            fetch_pc_d      = fetch_pc_q + 32'd4;
            out_d.valid     = 1'b1;
            out_d.pc        = fetch_pc_q;
            out_d.tag_rd    = lk_tag;
            out_d.tag_valid = lk_valid;
        end
        if (flush) begin
            out_d.valid = 1'b0;
        end
    end

    // State registers; reset dominates everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= 32'h0000_0000;
            out_q      <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
        end
    end

    assign ift_ifd_inf = out_q;

endmodule

// File: tb/tb_instruction_fetch_tag.sv
// Bench for instruction_fetch_tag: directed vector table, randomized
// run against a reference model, and a reset-during-stall sequence.
module tb_instruction_fetch_tag;
    import instruction_fetch_tag_pkg::*;

    logic         clk;
    logic         rst;
    logic         stall;
    logic         flush;
    logic         pc_src;
    logic [31:0]  branch_target;
    ifd_ift_inf_t in_s;
    ift_ifd_inf_t out_s;

    int n_checks = 0;
    int n_errors = 0;

    instruction_fetch_tag dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .ifd_ift_inf   (in_s),
        .ift_ifd_inf   (out_s)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             st, fl, ps, ms;
        logic [3:0]       en;
        logic [5:0]       set;
        logic [19:0]      tag;
        logic [31:0]      tgt;
        logic             ev;
        logic [31:0]      epc;
        logic [3:0]       etv;
        logic [3:0][19:0] etag;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, fl, ps, ms, input logic [3:0] en,
                                input logic [5:0] set, input logic [19:0] tag,
                                input logic [31:0] tgt, input logic ev,
                                input logic [31:0] epc, input logic [3:0] etv,
                                input logic [79:0] etag);
        vec_t v;
        v.st = st; v.fl = fl; v.ps = ps; v.ms = ms;
        v.en = en; v.set = set; v.tag = tag; v.tgt = tgt;
        v.ev = ev; v.epc = epc; v.etv = etv; v.etag = etag;
        return v;
    endfunction

    // reference model: flat arrays and the prose rules
    logic [31:0]      m_fetch;
    logic             m_valid;
    logic [31:0]      m_pc;
    logic [3:0]       m_tv;
    logic [3:0][19:0] m_tag;
    logic [19:0]      arr_tag [4][64];
    bit               arr_v   [4][64];

    task automatic model_reset();
        m_fetch = 0; m_valid = 0; m_pc = 0; m_tv = 0; m_tag = '0;
        for (int w = 0; w < 4; w++)
            for (int s = 0; s < 64; s++) arr_v[w][s] = 0;
    endtask

    task automatic model_step(input logic st, fl, ps, ms, input logic [3:0] en,
                              input logic [5:0] set, input logic [19:0] tag,
                              input logic [31:0] tgt);
        int s;
        // writes land before the lookup sees the array (same-cycle bypass)
        for (int w = 0; w < 4; w++)
            if (en[w]) begin arr_tag[w][set] = tag; arr_v[w][set] = 1; end
        if (ps) begin
            m_fetch = tgt; m_valid = 0;
        end else if (ms) begin
            m_fetch = m_pc; m_valid = 0;
        end else if (!st) begin
            s = int'(m_fetch / 64) % 64;
            m_valid = 1;
            m_pc = m_fetch;
            for (int w = 0; w < 4; w++) begin
                m_tv[w]  = arr_v[w][s];
                m_tag[w] = arr_tag[w][s];
            end
            m_fetch = m_fetch + 32'd4;
        end
        if (fl) m_valid = 0;
    endtask

    task automatic drive(input logic st, fl, ps, ms, input logic [3:0] en,
                         input logic [5:0] set, input logic [19:0] tag,
                         input logic [31:0] tgt);
        stall = st; flush = fl; pc_src = ps; branch_target = tgt;
        in_s.cache_miss = ms; in_s.update_tag_en = en;
        in_s.update_tag_set = set; in_s.update_tag = tag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // compares output; tags checked only for expected-valid ways unless all_tags
    task automatic check(input string name, input logic ev, input logic [31:0] epc,
                         input logic [3:0] etv, input logic [3:0][19:0] etag,
                         input bit all_tags);
        bit ok;
        ok = (out_s.valid === ev) && (out_s.pc === epc) && (out_s.tag_valid === etv);
        for (int w = 0; w < 4; w++)
            if ((all_tags || etv[w]) && (out_s.tag_rd[w] !== etag[w])) ok = 0;
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got valid=%0b pc=%h tv=%b tags=%h, want valid=%0b pc=%h tv=%b tags=%h",
                     name, out_s.valid, out_s.pc, out_s.tag_valid, out_s.tag_rd,
                     ev, epc, etv, etag);
        end
    endtask

    initial begin
        vec_t v;
        logic st, fl, ps, ms;
        logic [3:0] en;
        logic [5:0] set;
        logic [19:0] tag;
        logic [31:0] tgt;

        rst = 1'b1;
        drive(0, 0, 0, 0, 4'b0, 6'd0, 20'd0, 32'd0);
        tick();
        tick();
        check("reset", 0, 32'h0, 4'b0, '0, 1);
        rst = 1'b0;

        // directed table
        vecs.push_back(mk(0,0,0,0, 4'h0, 6'd0, 20'h0, 32'h0,       1, 32'h0,        4'b0000, 80'h0));
        vecs.push_back(mk(0,0,0,0, 4'h0, 6'd0, 20'h0, 32'h0,       1, 32'h4,        4'b0000, 80'h0));
        vecs.push_back(mk(0,0,0,0, 4'h0, 6'd0, 20'h0, 32'h0,       1, 32'h8,        4'b0000, 80'h0));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(1,0,0,1, 4'h0, 6'd0, 20'h0, 32'h0,   0, 32'h8,        4'b0000, 80'h0));
        vecs.push_back(mk(0,0,0,0, 4'h0, 6'd0, 20'h0, 32'h0,       1, 32'h8,        4'b0000, 80'h0));
        vecs.push_back(mk(0,0,1,0, 4'h1, 6'd0, 20'h0, 32'h0,       0, 32'h8,        4'b0000, 80'h0));
        vecs.push_back(mk(0,0,0,0, 4'h0, 6'd0, 20'h0, 32'h0,       1, 32'h0,        4'b0001, 80'h0));
        vecs.push_back(mk(0,0,1,0, 4'h2, 6'd1, 20'h0, 32'h40,      0, 32'h0,        4'b0001, 80'h0));
        vecs.push_back(mk(0,0,0,0, 4'h0, 6'd0, 20'h0, 32'h0,       1, 32'h40,       4'b0010, 80'h0));
        vecs.push_back(mk(0,0,1,0, 4'h0, 6'd0, 20'h0, 32'h0,       0, 32'h40,       4'b0010, 80'h0));
        vecs.push_back(mk(0,0,0,0, 4'h0, 6'd0, 20'h0, 32'h0,       1, 32'h0,        4'b0001, 80'h0));
        vecs.push_back(mk(0,0,1,1, 4'h0, 6'd0, 20'h0, 32'h100,     0, 32'h0,        4'b0001, 80'h0));
        vecs.push_back(mk(0,0,0,0, 4'h0, 6'd0, 20'h0, 32'h0,       1, 32'h100,      4'b0000, 80'h0));
        vecs.push_back(mk(0,0,0,0, 4'h0, 6'd0, 20'h0, 32'h0,       1, 32'h104,      4'b0000, 80'h0));
        vecs.push_back(mk(0,0,0,0, 4'h4, 6'd4, 20'hABCDE, 32'h0,   1, 32'h108,      4'b0100, {20'h0, 20'hABCDE, 40'h0}));
        vecs.push_back(mk(0,1,0,0, 4'h0, 6'd0, 20'h0, 32'h0,       0, 32'h10C,      4'b0100, {20'h0, 20'hABCDE, 40'h0}));
        vecs.push_back(mk(1,0,0,0, 4'h0, 6'd0, 20'h0, 32'h0,       0, 32'h10C,      4'b0100, {20'h0, 20'hABCDE, 40'h0}));
        vecs.push_back(mk(0,0,0,0, 4'h0, 6'd0, 20'h0, 32'h0,       1, 32'h110,      4'b0100, {20'h0, 20'hABCDE, 40'h0}));
        vecs.push_back(mk(0,0,1,0, 4'h0, 6'd0, 20'h0, 32'hFFFF_FFFC, 0, 32'h110,    4'b0100, {20'h0, 20'hABCDE, 40'h0}));
        vecs.push_back(mk(0,0,0,0, 4'h0, 6'd0, 20'h0, 32'h0,       1, 32'hFFFF_FFFC, 4'b0000, 80'h0));
        vecs.push_back(mk(0,0,0,0, 4'h0, 6'd0, 20'h0, 32'h0,       1, 32'h0,        4'b0001, 80'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.st, v.fl, v.ps, v.ms, v.en, v.set, v.tag, v.tgt);
            tick();
            check($sformatf("vec%0d", i), v.ev, v.epc, v.etv, v.etag, 0);
        end

        // randomized run against the model
        rst = 1'b1;
        drive(0, 0, 0, 0, 4'b0, 6'd0, 20'd0, 32'd0);
        tick();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 400; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            ps  = ($urandom_range(0, 9) == 0);
            ms  = ($urandom_range(0, 9) == 0);
            en  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            set = 6'($urandom_range(0, 7));
            tag = 20'($urandom);
            tgt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            drive(st, fl, ps, ms, en, set, tag, tgt);
            model_step(st, fl, ps, ms, en, set, tag, tgt);
            tick();
            check($sformatf("rand%0d", i), m_valid, m_pc, m_tv, m_tag, 0);
        end

        // reset arriving mid-stall right after a tag update
        drive(1, 0, 0, 0, 4'hF, 6'd5, 20'h12345, 32'h0);
        tick();
        drive(1, 0, 0, 0, 4'h0, 6'd0, 20'h0, 32'h0);
        tick();
        rst = 1'b1;
        drive(1, 0, 0, 0, 4'h1, 6'd5, 20'h54321, 32'h0);
        tick();
        check("rst_mid_stall", 0, 32'h0, 4'b0, '0, 1);
        rst = 1'b0;
        drive(0, 0, 0, 0, 4'h0, 6'd0, 20'h0, 32'h0);
        tick();
        check("post_rst_pc0", 1, 32'h0, 4'b0, '0, 0);
        drive(0, 0, 1, 0, 4'h0, 6'd0, 20'h0, 32'h140);
        tick();
        drive(0, 0, 0, 0, 4'h0, 6'd0, 20'h0, 32'h0);
        tick();
        check("post_rst_set5", 1, 32'h140, 4'b0, '0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_tag.md
INSTRUCTION_FETCH_TAG -- requirements
Module: instruction_fetch_tag

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 stall  input  1  hold fetch PC and output register.
REQ-005 flush  input  1  invalidate the instruction on the output next cycle.
REQ-006 pc_src  input  1  redirect fetch to branch_target.
REQ-007 branch_target  input  32  redirect address, word aligned.
REQ-008 ifd_ift_inf  input  ifd_ift_inf_t  fields:
- cache_miss (1): the instruction currently on ift_ifd_inf missed.
- update_tag_en (4): one-hot way write enable.
- update_tag_set (6): set index.
- update_tag (20): tag to write.
REQ-009 ift_ifd_inf  output  ift_ifd_inf_t  fields:
- valid (1).
- pc (32).
- tag_rd[4] (20 each).
- tag_valid[4] (1 each).

Function
REQ-010 SHALL hold constants ICACHE_CL_SIZE=64 (bytes), ICACHE_NUM_WAYS=4 and ICACHE_NUM_SETS=64.
REQ-011 SHALL split the address as offset=[5:0], set=[11:6], tag=[31:12].
REQ-012 SHALL keep a fetch_pc register and a tag array of 4 ways x 64 sets x (20-bit tag + valid bit).
REQ-013 Normal cycle (no rst, pc_src, cache_miss or stall), output register loads:
- valid=1, pc=fetch_pc.
- tag_rd[w] and tag_valid[w] = array[w][fetch_pc set] for every way.
REQ-014 Normal cycle SHALL also set fetch_pc <= fetch_pc+4, wrapping modulo 2^32.
REQ-015 pc_src=1 SHALL set fetch_pc <= branch_target and output valid <= 0, regardless of stall or cache_miss.
REQ-016 cache_miss=1 with pc_src=0 SHALL set fetch_pc <= ift_ifd_inf.pc (replay) and output valid <= 0, regardless of stall.
REQ-017 stall=1 with neither pc_src nor cache_miss SHALL hold fetch_pc and all output fields unchanged.
REQ-018 flush=1 SHALL force output valid <= 0 next cycle; other fields follow REQ-013 to REQ-017.
REQ-019 Next-PC priority SHALL be: rst > pc_src > cache_miss > stall > increment.
REQ-020 Each update_tag_en[w]=1 SHALL write array[w][update_tag_set] <= {update_tag, valid=1}, independent of stall, flush and pc_src.
REQ-021 Multiple enable bits SHALL write all selected ways.
REQ-022 A tag write and a lookup of the same set/way in the same cycle SHALL present the newly written tag and valid=1 (write bypass).
REQ-023 Hit comparison SHALL NOT be done here; it is done downstream from tag_rd/tag_valid.

Reset
REQ-024 While rst=1 SHALL set fetch_pc=0x0000_0000 and output valid=0, pc=0, tag_rd=0, tag_valid=0.
REQ-025 While rst=1 SHALL clear all 256 valid bits; tag storage need not be reset.
REQ-026 Reset SHALL take priority over every other input, including an in-progress stall or tag update.

Structure
REQ-027 ICACHE_* constants, ifd_ift_inf_t and ift_ifd_inf_t SHALL live in the shared core package.
REQ-028 Tag/valid storage SHALL be one sub-module, icache_tag_array: 4-way, 64-set, one read port, per-way write enable, valid reset, write bypass.

Verification
REQ-029 Release rst, no stimulus -> outputs pc 0x0, 0x4, 0x8… on consecutive cycles, valid=1, tag_valid=0000.
REQ-030 Output pc=0x8 with cache_miss=1 and stall=1 for 6 cycles -> output valid=0 and held; stall drop -> next output pc=0x8.
REQ-031 update_tag_en=0001, set=0, tag=0 with stall drop; then fetch pc 0x0 -> tag_valid[0]=1, tag_rd[0]=0, other ways 0.
REQ-032 update_tag_en=0010, set=1, tag=0; then fetch pc 0x40 -> tag_valid[1]=1, tag_rd[1]=0; pc 0x0 still shows way 0 valid.
REQ-033 pc_src=1, branch_target=0x100, with cache_miss=1 the same cycle -> one invalid output, then pc 0x100, 0x104.
REQ-034 Assert rst mid-stall after a tag update -> all tag_valid=0 on next lookup; pc restarts at 0x0.
